// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch and data
// access. Data wins by default; a streak counter bounds how long fetch can starve.
module mem_arbiter #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic [31:0]     i_rdata,
  output logic            i_ready,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            stall_i,
  output logic            stall_d
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [XLEN-1:0]   d_rdata_q, d_rdata_d;
  logic              grant_d;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    grant_d     = d_req && !(i_req && (streak_q == LIMIT));

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          // Streak only grows while a fetch is actually waiting behind data.
          if (!i_req)
            streak_d = 4'd0;
          else if (streak_q != LIMIT)
            streak_d = streak_q + 4'd1;
        end else if (i_req) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
          streak_d    = 4'd0;
        end
      end
      BUSY_I: begin
        if (mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          i_rdata_d = mem_addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
          i_ready_d = 1'b1;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          d_rdata_d = mem_we_q ? '0 : mem_rdata;
          d_ready_d = 1'b1;
        end
      end
      // One dead cycle so the retiring requester's still-high req is not re-granted.
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      streak_q    <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall_i   = i_req & ~i_ready_q;
  assign stall_d   = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a memory responder model, per-port expected
// read-data queues and a grant log checked against the arbitration rules.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [63:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [63:0] d_rdata;
  logic        d_ready;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        stall_i;
  logic        stall_d;

  mem_arbiter #(.XLEN(64), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_i(stall_i), .stall_d(stall_d)
  );

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [3:0]  streak;
    int          cyc;
  } gnt_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [63:0] d_exp_q[$];
  logic [31:0] i_exp_q[$];
  gnt_t        gnt_q[$];
  logic        mem_auto = 1'b1;
  int          ack_wait = 0;
  int          wait_cnt = 0;
  logic        mreq_prev = 1'b0;
  int          mreq_cycles, stall_d_cycles, stall_i_cycles;
  int          d_ready_cnt = 0, i_ready_cnt = 0;
  int          d_ready_cyc, i_ready_cyc, req_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_val(input logic [63:0] a);
    logic [63:0] b;
    b = {a[63:3], 3'b000};
    case (b)
      64'h40:  return 64'hDEADBEEF_CAFEF00D;
      64'h100: return 64'h11112222_33334444;
      default: return {b[31:0], ~b[31:0]};
    endcase
  endfunction

  function automatic logic [31:0] word_sel(input logic [63:0] a);
    logic [63:0] v;
    v = mem_val(a);
    return a[2] ? v[63:32] : v[31:0];
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Memory responder: acks after ack_wait cycles of mem_req being high.
  initial forever begin
    @(negedge clk);
    if (mem_auto) begin
      mem_ack = 1'b0;
      if (mem_req) begin
        if (wait_cnt == ack_wait) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_val(mem_addr);
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Monitor: grant log, activity counters and scoreboard pops.
  initial forever begin
    gnt_t g;
    @(negedge clk);
    if (mem_req && !mreq_prev) begin
      g.addr = mem_addr; g.we = mem_we; g.wdata = mem_wdata;
      g.streak = dut.streak_q; g.cyc = cyc;
      gnt_q.push_back(g);
    end
    mreq_prev = mem_req;
    if (mem_req) mreq_cycles++;
    if (stall_d) stall_d_cycles++;
    if (stall_i) stall_i_cycles++;
    if (d_ready) begin
      d_ready_cnt++;
      d_ready_cyc = cyc;
      if (d_exp_q.size() == 0) chk("d_unexpected_ready", 1, 0);
      else chk("d_rdata", d_rdata, d_exp_q.pop_front());
    end
    if (i_ready) begin
      i_ready_cnt++;
      i_ready_cyc = cyc;
      if (i_exp_q.size() == 0) chk("i_unexpected_ready", 1, 0);
      else chk("i_rdata", {32'h0, i_rdata}, {32'h0, i_exp_q.pop_front()});
    end
  end

  task automatic d_access(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
    bit got = 0;
    d_exp_q.push_back(we ? 64'h0 : mem_val(addr));
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (d_ready) begin got = 1; break; end
    end
    if (!got) chk("d_timeout", 0, 1);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic i_access(input logic [63:0] addr);
    bit got = 0;
    i_exp_q.push_back(word_sel(addr));
    i_req = 1'b1; i_addr = addr;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (i_ready) begin got = 1; break; end
    end
    if (!got) chk("i_timeout", 0, 1);
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic start_test;
    @(posedge clk); #1;
    gnt_q.delete();
    mreq_cycles = 0; stall_d_cycles = 0; stall_i_cycles = 0;
    req_cyc = cyc;
  endtask

  initial begin
    int dcnt;
    rst = 1'b0; i_req = 1'b1; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    #3;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_readies", {i_ready, d_ready}, 0);
    chk("rst_rdata", d_rdata | {32'h0, i_rdata}, 0);
    chk("rst_stall_i", stall_i, 1);
    chk("rst_stall_d", stall_d, 0);
    i_req = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk);

    // Single zero-wait load
    ack_wait = 0;
    start_test();
    d_access(1'b0, 64'h40, 64'h0);
    chk("t1_latency", d_ready_cyc - req_cyc, 2);
    chk("t1_mreq_cycles", mreq_cycles, 1);
    chk("t1_stall_d_cycles", stall_d_cycles, 2);
    chk("t1_grants", gnt_q.size(), 1);
    if (gnt_q.size() >= 1) begin
      chk("t1_addr", gnt_q[0].addr, 64'h40);
      chk("t1_we", gnt_q[0].we, 0);
    end

    // Fetch word select, ack three cycles into BUSY
    ack_wait = 2;
    start_test();
    i_access(64'h104);
    chk("t2_latency", i_ready_cyc - req_cyc, 4);
    if (gnt_q.size() >= 1) begin
      chk("t2_addr", gnt_q[0].addr, 64'h104);
      chk("t2_we", gnt_q[0].we, 0);
    end else chk("t2_grants", gnt_q.size(), 1);
    chk("t2_hold", {32'h0, i_rdata}, 64'h11112222);
    start_test();
    i_access(64'h100);
    chk("t2_hold_lo", {32'h0, i_rdata}, 64'h33334444);

    // Collision: data store wins, fetch follows after RESP
    ack_wait = 0;
    start_test();
    fork
      d_access(1'b1, 64'h80, 64'h55);
      i_access(64'h204);
    join
    chk("t3_grants", gnt_q.size(), 2);
    if (gnt_q.size() >= 2) begin
      chk("t3_d_we", gnt_q[0].we, 1);
      chk("t3_d_addr", gnt_q[0].addr, 64'h80);
      chk("t3_d_wdata", gnt_q[0].wdata, 64'h55);
      chk("t3_i_addr", gnt_q[1].addr, 64'h204);
      chk("t3_i_gap", gnt_q[1].cyc - d_ready_cyc, 2);
    end
    chk("t3_i_latency", i_ready_cyc - req_cyc, 5);
    chk("t3_stall_i_cycles", stall_i_cycles, 5);

    // Starvation guard with data re-requesting back to back
    start_test();
    fork
      i_access(64'h2000);
      for (int k = 0; k < 6; k++) d_access(1'b0, 64'h1000 + 64'(k * 8), 64'h0);
    join
    chk("t4_grants", gnt_q.size(), 7);
    if (gnt_q.size() >= 7) begin
      dcnt = 0;
      for (int k = 0; k < 7; k++) begin
        if (k == 4) chk("t4_i_slot", gnt_q[k].addr, 64'h2000);
        else begin
          chk("t4_d_slot", gnt_q[k].addr, 64'h1000 + 64'(dcnt * 8));
          dcnt++;
        end
      end
      chk("t4_streak_before_i", gnt_q[3].streak, 4);
      chk("t4_streak_after_i", gnt_q[4].streak, 0);
    end

    // Reset in the middle of a data transaction
    mem_auto = 1'b0;
    mem_ack = 1'b0;
    dcnt = d_ready_cnt;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h300;
    @(posedge clk); #1;
    chk("t5_busy", {63'h0, mem_req}, 1);
    #2 rst = 1'b0;
    #1;
    chk("t5_mem_req_async", mem_req, 0);
    chk("t5_outputs", mem_addr | mem_wdata | d_rdata | {32'h0, i_rdata}, 0);
    chk("t5_ctrl", {mem_we, i_ready, d_ready}, 0);
    chk("t5_state", 64'(dut.state_q), 0);
    d_req = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 64'hABCD;
    @(posedge clk); #1; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_ready", d_ready_cnt - dcnt, 0);
    chk("t5_idle", 64'(dut.state_q), 0);
    chk("t5_mem_req_after", mem_req, 0);

    // Spurious ack while idle, then a normal load
    dcnt = d_ready_cnt + i_ready_cnt;
    mem_ack = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_no_ready", d_ready_cnt + i_ready_cnt - dcnt, 0);
    chk("t6_idle", 64'(dut.state_q), 0);
    chk("t6_rdata_held", d_rdata, 0);
    mem_auto = 1'b1;
    start_test();
    d_access(1'b0, 64'h40, 64'h0);
    chk("t6_load_latency", d_ready_cyc - req_cyc, 2);

    repeat (3) @(posedge clk);
    chk("sb_d_drained", d_exp_q.size(), 0);
    chk("sb_i_drained", i_exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares a single-ported unified memory between the core's instruction-fetch port and its data-memory port. Each requester drives a held request; the arbiter runs a request/acknowledge transaction on the shared memory and returns a one-cycle ready pulse with read data. Stall outputs feed the hazard unit, which freezes fetch or the memory stage while a transaction is outstanding. Data requests win by default; a streak counter prevents fetch starvation.

## Interface

- `XLEN`, 64, address and data-memory width
- `STARVE_LIMIT`, 4, maximum consecutive data grants while a fetch request waits (range 1–15)

Ports:

- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `i_req`  in  1  fetch request; held until `i_ready`
- `i_addr`  in  XLEN  fetch byte address, 4-byte aligned
- `i_rdata`  out  32  instruction word; valid while `i_ready`=1
- `i_ready`  out  1  one-cycle fetch completion pulse
- `d_req`  in  1  data request; held until `d_ready`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  XLEN  data byte address, 8-byte aligned
- `d_wdata`  in  XLEN  store data
- `d_rdata`  out  XLEN  load data; valid while `d_ready`=1 (0 for stores)
- `d_ready`  out  1  one-cycle data completion pulse
- `mem_req`  out  1  shared memory request; held until `mem_ack`
- `mem_we`  out  1  shared memory write enable
- `mem_addr`  out  XLEN  shared memory address
- `mem_wdata`  out  XLEN  shared memory write data
- `mem_ack`  in  1  one-cycle completion from memory; `mem_rdata` valid in the same cycle
- `mem_rdata`  in  XLEN  shared memory read data
- `stall_i`  out  1  combinational: `i_req & ~i_ready`
- `stall_d`  out  1  combinational: `d_req & ~d_ready`

## Operation

- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE arbitration:
  - Only `d_req`: grant D.
  - Only `i_req`: grant I.
  - Both: grant D unless `streak == STARVE_LIMIT`, in which case grant I.
  - Neither: stay in IDLE.
- On grant, register `mem_addr`/`mem_we`/`mem_wdata` from the winner. For I, `mem_we`=0 and `mem_wdata`=0. Set `mem_req`=1 and enter BUSY_x.
- BUSY_x: hold all `mem_*` outputs stable. On `mem_ack`:
  - Clear `mem_req`.
  - Capture read data into the winner's `rdata` register. For I, `i_rdata` = `mem_rdata[63:32]` if `i_addr[2]`=1, else `mem_rdata[31:0]`. For a D store, `d_rdata`=0.
  - Set the winner's `ready`=1 and enter RESP.
- RESP: for exactly one cycle, `ready`=1 and `mem_req`=0. Then clear `ready` and return to IDLE.
  - RESP prevents re-granting a request the requester is retiring this cycle.
- Streak counter, 4 bits:
  - On a D grant with `i_req`=1: +1, saturating at `STARVE_LIMIT`.
  - On any I grant, or any D grant with `i_req`=0: reset to 0.
- `mem_ack` in IDLE or RESP is ignored: no state change, no ready pulse.
- Requesters must keep `req` and their payload stable until `ready`. A request dropped before `ready` is a protocol violation; the transaction still completes and the pulse is still issued.
- `rdata` registers hold their last captured value after the pulse. They change only on capture or reset.

## Timing

- Reset (`rst`=0, asynchronous):
  - State becomes IDLE and streak becomes 0.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` = 0.
  - `i_ready`, `d_ready` = 0; `i_rdata`, `d_rdata` = 0.
  - `stall_*` still follow their equations: `stall_i`=`i_req`, `stall_d`=`d_req`.
- Reset mid-transaction: `mem_req` drops immediately and the transaction is abandoned. A `mem_ack` arriving after reset release is ignored.
- Latency: request first sampled in IDLE at edge 0.
  - `mem_req`=1 from cycle 1.
  - `mem_ack` in cycle k (k≥1) gives `ready` in cycle k+1.
  - IDLE in cycle k+2.
  - Minimum request-to-ready latency is 2 cycles. One transaction completes every 3 cycles at best.
- Simultaneous `i_req` and `d_req` arrival: only the arbitration rule applies. The loser's stall stays asserted for the entire winner transaction.
- Outputs `mem_*`, `ready`, and `rdata` are registered. `stall_*` are combinational.

## Test plan

- **Single load with zero wait.** `d_req`=1, `d_we`=0, `d_addr`=0x40; memory acks in the first BUSY cycle with `mem_rdata`=0xDEADBEEF_CAFEF00D.
  - `mem_req` is high for 1 cycle with `mem_addr`=0x40.
  - `d_ready` pulses 2 cycles after the request with `d_rdata`=0xDEADBEEF_CAFEF00D.
  - `stall_d` is high for 2 cycles.
- **Fetch word select.** `i_addr`=0x104, `mem_rdata`=0x11112222_33334444, ack after 3 cycles.
  - `mem_addr`=0x104, `mem_we`=0.
  - `i_rdata`=0x11112222 in the `i_ready` cycle.
  - Repeat with `i_addr`=0x100: `i_rdata`=0x33334444.
- **Collision and data priority.** `i_req` and `d_req` (store, `d_addr`=0x80, `d_wdata`=0x55) rise in the same cycle.
  - D is served first: `mem_we`=1, `mem_wdata`=0x55.
  - I is granted in the IDLE cycle after the RESP cycle of the D transaction.
  - `stall_i` stays high throughout.
- **Starvation guard.** `STARVE_LIMIT`=4; `i_req` held while `d_req` re-asserts after every `d_ready`.
  - Exactly 4 D transactions occur, then 1 I transaction, then D resumes.
  - Streak is 0 after the I grant.
- **Reset mid-transaction.** Assert `rst`=0 during BUSY_D, release, then pulse `mem_ack` once.
  - `mem_req`=0 asynchronously.
  - No `d_ready` pulse occurs.
  - All registered outputs are 0 and the FSM is in IDLE.
- **Spurious ack.** `mem_ack` pulsed in IDLE with no requests pending.
  - No ready pulse and no state change.
  - A subsequent load completes normally.
